// File: rtl/om_pkg.sv
// Shared definitions for the order manager: exec report codes, intake FSM states,
// the default buy side code and the slot-index width helper.
package om_pkg;

    localparam logic [1:0] EXEC_FILL      = 2'd0;
    localparam logic [1:0] EXEC_PARTIAL   = 2'd1;
    localparam logic [1:0] EXEC_REJECT    = 2'd2;
    localparam logic [1:0] EXEC_CANCELLED = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_RISK_WAIT = 2'd1,
        ST_SEND      = 2'd2
    } intake_state_t;

    localparam logic [7:0] BUY_CODE_DEFAULT = 8'd1;

    function automatic int slot_w(input int num_slots);
        return $clog2(num_slots);
    endfunction

endpackage

// File: rtl/order_slot.sv
// One order table entry: liveness, generation, remaining quantity and fill-timeout age.
// Reports terminal events for this cycle so the top can count them.
module order_slot
    import om_pkg::*;
#(
    parameter int QTY_W        = 32,
    parameter int GEN_W        = 6,
    parameter int FILL_TIMEOUT = 1024
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             alloc,
    input  logic [QTY_W-1:0] alloc_qty,
    input  logic             exec_hit,
    input  logic [1:0]       exec_type,
    input  logic [QTY_W-1:0] exec_qty,
    output logic             live,
    output logic [GEN_W-1:0] gen,
    output logic             filled,
    output logic             rejected,
    output logic             timed_out
);

    localparam int AGE_W = $clog2(FILL_TIMEOUT) + 1;

    logic [QTY_W-1:0] remaining;
    logic [AGE_W-1:0] age;
    logic             qty_exec;
    logic             cancelled;
    logic             release_slot;

    // exec_hit is only raised for a live slot with a matching generation
    always_comb begin
        qty_exec     = exec_hit && (exec_type == EXEC_FILL || exec_type == EXEC_PARTIAL);
        filled       = qty_exec && (exec_type == EXEC_FILL || exec_qty >= remaining);
        rejected     = exec_hit && (exec_type == EXEC_REJECT);
        cancelled    = exec_hit && (exec_type == EXEC_CANCELLED);
        timed_out    = live && !exec_hit && (age == AGE_W'(FILL_TIMEOUT - 1));
        release_slot = filled || rejected || cancelled || timed_out;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            live      <= 1'b0;
            gen       <= '0;
            remaining <= '0;
            age       <= '0;
        end else if (alloc) begin
            live      <= 1'b1;
            remaining <= alloc_qty;
            age       <= '0;
        end else if (release_slot) begin
            live <= 1'b0;
            gen  <= gen + GEN_W'(1);
        end else begin
            if (qty_exec) remaining <= remaining - exec_qty;
            if (live && age != '1) age <= age + AGE_W'(1);
        end
    end

endmodule

// File: rtl/multi_order_manager.sv
// Multi-slot order manager: intake FSM with risk gate and encoder handshake, slot table
// keyed by {generation, slot}, exec report decode and lifecycle counters.
module multi_order_manager
    import om_pkg::*;
#(
    parameter int         NUM_SLOTS    = 4,
    parameter int         PRICE_W      = 32,
    parameter int         QTY_W        = 32,
    parameter int         ID_W         = 8,
    parameter int         FILL_TIMEOUT = 1024,
    parameter logic [7:0] BUY_CODE     = BUY_CODE_DEFAULT
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic [PRICE_W-1:0]            best_bid_price,
    input  logic [PRICE_W-1:0]            best_ask_price,
    input  logic                          tob_valid,
    input  logic                          trade_signal,
    input  logic [QTY_W-1:0]              trade_qty,
    input  logic [7:0]                    trade_side,
    output logic                          trade_ready,
    output logic                          risk_req,
    input  logic                          risk_valid,
    input  logic                          risk_approved,
    output logic                          order_valid,
    input  logic                          order_ready,
    output logic [ID_W-1:0]               order_id,
    output logic [QTY_W-1:0]              order_qty,
    output logic [PRICE_W-1:0]            order_price,
    output logic [7:0]                    order_side,
    input  logic                          exec_valid,
    input  logic [ID_W-1:0]               exec_id,
    input  logic [1:0]                    exec_type,
    input  logic [QTY_W-1:0]              exec_qty,
    output logic [slot_w(NUM_SLOTS):0]    open_orders,
    output logic [31:0]                   order_count,
    output logic [31:0]                   filled_count,
    output logic [31:0]                   rejected_count,
    output logic [31:0]                   timeout_count,
    output logic [31:0]                   stray_count,
    output logic [1:0]                    state_out
);

    localparam int SLOT_W = slot_w(NUM_SLOTS);
    localparam int GEN_W  = ID_W - SLOT_W;
    localparam int CNT_W  = SLOT_W + 1;

    intake_state_t        state, state_next;
    logic [NUM_SLOTS-1:0] live, alloc_vec, hit_vec, filled_vec, rejected_vec, timeout_vec;
    logic [GEN_W-1:0]     gen [NUM_SLOTS];
    logic [SLOT_W-1:0]    free_slot, res_slot, exec_slot;
    logic [GEN_W-1:0]     exec_gen;
    logic [CNT_W-1:0]     live_cnt, timeout_cnt;
    logic                 any_free, accept, handshake, risk_reject, exec_match;

    // Lowest-index free slot wins
    always_comb begin
        any_free  = 1'b0;
        free_slot = '0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (!live[i]) begin
                any_free  = 1'b1;
                free_slot = SLOT_W'(i);
            end
        end
    end

    assign trade_ready = (state == ST_IDLE) && any_free && tob_valid;
    assign accept      = trade_signal && trade_ready;
    assign risk_req    = (state == ST_RISK_WAIT);
    assign order_valid = (state == ST_SEND);
    assign handshake   = order_valid && order_ready;
    assign risk_reject = risk_req && risk_valid && !risk_approved;
    assign state_out   = state;

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:      if (accept) state_next = ST_RISK_WAIT;
            ST_RISK_WAIT: if (risk_valid) state_next = risk_approved ? ST_SEND : ST_IDLE;
            ST_SEND:      if (order_ready) state_next = ST_IDLE;
            default:      state_next = ST_IDLE;
        endcase
    end

    // The free slot cannot change while the order is in flight: only live slots are freed
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state       <= ST_IDLE;
            order_qty   <= '0;
            order_side  <= '0;
            order_price <= '0;
            order_id    <= '0;
            res_slot    <= '0;
        end else begin
            state <= state_next;
            if (accept) begin
                order_qty   <= trade_qty;
                order_side  <= trade_side;
                order_price <= (trade_side == BUY_CODE) ? best_ask_price : best_bid_price;
                order_id    <= {gen[free_slot], free_slot};
                res_slot    <= free_slot;
            end
        end
    end

    assign exec_slot  = exec_id[SLOT_W-1:0];
    assign exec_gen   = exec_id[ID_W-1:SLOT_W];
    assign exec_match = exec_valid && live[exec_slot] && (gen[exec_slot] == exec_gen);

    for (genvar s = 0; s < NUM_SLOTS; s++) begin : g_slot
        assign alloc_vec[s] = handshake && (res_slot == SLOT_W'(s));
        assign hit_vec[s]   = exec_match && (exec_slot == SLOT_W'(s));

        order_slot #(
            .QTY_W        (QTY_W),
            .GEN_W        (GEN_W),
            .FILL_TIMEOUT (FILL_TIMEOUT)
        ) u_slot (
            .clk       (clk),
            .rstn      (rstn),
            .alloc     (alloc_vec[s]),
            .alloc_qty (order_qty),
            .exec_hit  (hit_vec[s]),
            .exec_type (exec_type),
            .exec_qty  (exec_qty),
            .live      (live[s]),
            .gen       (gen[s]),
            .filled    (filled_vec[s]),
            .rejected  (rejected_vec[s]),
            .timed_out (timeout_vec[s])
        );
    end

    always_comb begin
        live_cnt    = '0;
        timeout_cnt = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            live_cnt    = live_cnt + CNT_W'(live[i]);
            timeout_cnt = timeout_cnt + CNT_W'(timeout_vec[i]);
        end
    end

    assign open_orders = live_cnt;

    // A risk reject and an exec REJECT may land in the same cycle; both count
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            order_count    <= '0;
            filled_count   <= '0;
            rejected_count <= '0;
            timeout_count  <= '0;
            stray_count    <= '0;
        end else begin
            order_count    <= order_count + 32'(handshake) + 32'(risk_reject);
            filled_count   <= filled_count + 32'(|filled_vec);
            rejected_count <= rejected_count + 32'(|rejected_vec) + 32'(risk_reject);
            timeout_count  <= timeout_count + 32'(timeout_cnt);
            stray_count    <= stray_count + 32'(exec_valid && !exec_match);
        end
    end

endmodule

// File: tb/tb_multi_order_manager.sv
// Directed bench for multi_order_manager: order lifecycle, slot reuse, partial fills,
// timeout, stray reports, payload hold and async reset.
module tb_multi_order_manager;

    logic        clk = 1'b0;
    logic        rstn;
    logic [31:0] best_bid_price, best_ask_price;
    logic        tob_valid, trade_signal;
    logic [31:0] trade_qty;
    logic [7:0]  trade_side;
    logic        trade_ready, risk_req, risk_valid, risk_approved;
    logic        order_valid, order_ready;
    logic [7:0]  order_id;
    logic [31:0] order_qty, order_price;
    logic [7:0]  order_side;
    logic        exec_valid;
    logic [7:0]  exec_id;
    logic [1:0]  exec_type;
    logic [31:0] exec_qty;
    logic [2:0]  open_orders;
    logic [31:0] order_count, filled_count, rejected_count, timeout_count, stray_count;
    logic [1:0]  state_out;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    multi_order_manager dut (
        .clk            (clk),
        .rstn           (rstn),
        .best_bid_price (best_bid_price),
        .best_ask_price (best_ask_price),
        .tob_valid      (tob_valid),
        .trade_signal   (trade_signal),
        .trade_qty      (trade_qty),
        .trade_side     (trade_side),
        .trade_ready    (trade_ready),
        .risk_req       (risk_req),
        .risk_valid     (risk_valid),
        .risk_approved  (risk_approved),
        .order_valid    (order_valid),
        .order_ready    (order_ready),
        .order_id       (order_id),
        .order_qty      (order_qty),
        .order_price    (order_price),
        .order_side     (order_side),
        .exec_valid     (exec_valid),
        .exec_id        (exec_id),
        .exec_type      (exec_type),
        .exec_qty       (exec_qty),
        .open_orders    (open_orders),
        .order_count    (order_count),
        .filled_count   (filled_count),
        .rejected_count (rejected_count),
        .timeout_count  (timeout_count),
        .stray_count    (stray_count),
        .state_out      (state_out)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic place(input logic [31:0] qty, input logic [7:0] side);
        trade_signal = 1'b1;
        trade_qty    = qty;
        trade_side   = side;
        @(negedge clk);
        trade_signal = 1'b0;
    endtask

    task automatic decide(input logic ok);
        risk_valid    = 1'b1;
        risk_approved = ok;
        @(negedge clk);
        risk_valid    = 1'b0;
        risk_approved = 1'b0;
    endtask

    task automatic send();
        order_ready = 1'b1;
        @(negedge clk);
        order_ready = 1'b0;
    endtask

    task automatic report(input logic [7:0] id, input logic [1:0] typ, input logic [31:0] qty);
        exec_valid = 1'b1;
        exec_id    = id;
        exec_type  = typ;
        exec_qty   = qty;
        @(negedge clk);
        exec_valid = 1'b0;
    endtask

    task automatic open_order(input logic [31:0] qty, input logic [7:0] side,
                              input logic [7:0] exp_id, input logic [31:0] exp_price);
        place(qty, side);
        decide(1'b1);
        check_eq("open_valid", 32'(order_valid), 32'd1);
        check_eq("open_id", 32'(order_id), 32'(exp_id));
        check_eq("open_price", order_price, exp_price);
        send();
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rstn = 1'b0; tob_valid = 1'b0; trade_signal = 1'b0; trade_qty = '0; trade_side = '0;
        risk_valid = 1'b0; risk_approved = 1'b0; order_ready = 1'b0;
        exec_valid = 1'b0; exec_id = '0; exec_type = '0; exec_qty = '0;
        best_bid_price = 32'd4990; best_ask_price = 32'd5000;
        repeat (2) @(negedge clk);
        check_eq("rst_state", 32'(state_out), 32'd0);
        check_eq("rst_valid", 32'(order_valid), 32'd0);
        check_eq("rst_riskreq", 32'(risk_req), 32'd0);
        check_eq("rst_open", 32'(open_orders), 32'd0);
        check_eq("rst_ready", 32'(trade_ready), 32'd0);
        check_eq("rst_ocount", order_count, 32'd0);
        rstn = 1'b1; tob_valid = 1'b1;
        @(negedge clk);
        check_eq("idle_ready", 32'(trade_ready), 32'd1);

        // basic buy, approve, fill
        place(32'd100, 8'd1);
        check_eq("t1_riskreq", 32'(risk_req), 32'd1);
        check_eq("t1_state", 32'(state_out), 32'd1);
        risk_valid = 1'b1; risk_approved = 1'b1;
        #1 check_eq("t1_valid_at_R", 32'(order_valid), 32'd0);
        @(negedge clk);
        risk_valid = 1'b0; risk_approved = 1'b0;
        check_eq("t1_valid", 32'(order_valid), 32'd1);
        check_eq("t1_price", order_price, 32'd5000);
        check_eq("t1_qty", order_qty, 32'd100);
        check_eq("t1_id", 32'(order_id), 32'h00);
        check_eq("t1_side", 32'(order_side), 32'd1);
        send();
        check_eq("t1_open", 32'(open_orders), 32'd1);
        check_eq("t1_ocount", order_count, 32'd1);
        check_eq("t1_state_idle", 32'(state_out), 32'd0);
        report(8'h00, 2'd0, 32'd100);
        check_eq("t1_filled", filled_count, 32'd1);
        check_eq("t1_open_after", 32'(open_orders), 32'd0);

        // risk reject
        place(32'd50, 8'd2);
        decide(1'b0);
        check_eq("t2_valid", 32'(order_valid), 32'd0);
        check_eq("t2_state", 32'(state_out), 32'd0);
        check_eq("t2_rejected", rejected_count, 32'd1);
        check_eq("t2_ocount", order_count, 32'd2);
        check_eq("t2_ready", 32'(trade_ready), 32'd1);

        // fill all slots, reject slot 2, reuse with new generation
        open_order(32'd10, 8'd2, 8'h04, 32'd4990);
        open_order(32'd10, 8'd1, 8'h01, 32'd5000);
        open_order(32'd10, 8'd1, 8'h02, 32'd5000);
        open_order(32'd10, 8'd1, 8'h03, 32'd5000);
        check_eq("t3_full_ready", 32'(trade_ready), 32'd0);
        check_eq("t3_open4", 32'(open_orders), 32'd4);
        report(8'h02, 2'd2, 32'd0);
        check_eq("t3_rejected", rejected_count, 32'd2);
        check_eq("t3_open3", 32'(open_orders), 32'd3);
        check_eq("t3_ready", 32'(trade_ready), 32'd1);
        open_order(32'd10, 8'd1, 8'h06, 32'd5000);
        report(8'h04, 2'd3, 32'd0);
        report(8'h01, 2'd3, 32'd0);
        report(8'h03, 2'd3, 32'd0);
        report(8'h06, 2'd3, 32'd0);
        check_eq("t3_open0", 32'(open_orders), 32'd0);
        check_eq("t3_rej_unch", rejected_count, 32'd2);
        check_eq("t3_fill_unch", filled_count, 32'd1);
        check_eq("t3_ocount", order_count, 32'd7);

        // partial fills
        open_order(32'd100, 8'd1, 8'h08, 32'd5000);
        report(8'h08, 2'd1, 32'd30);
        check_eq("t4_open_p1", 32'(open_orders), 32'd1);
        check_eq("t4_fill_p1", filled_count, 32'd1);
        report(8'h08, 2'd1, 32'd70);
        check_eq("t4_open_p2", 32'(open_orders), 32'd0);
        check_eq("t4_fill_p2", filled_count, 32'd2);

        // timeout boundary then stray report with the stale id
        open_order(32'd5, 8'd1, 8'h0C, 32'd5000);
        repeat (1023) @(negedge clk);
        check_eq("t5_live_last", 32'(open_orders), 32'd1);
        check_eq("t5_to_before", timeout_count, 32'd0);
        @(negedge clk);
        check_eq("t5_open", 32'(open_orders), 32'd0);
        check_eq("t5_timeout", timeout_count, 32'd1);
        report(8'h0C, 2'd0, 32'd5);
        check_eq("t5_stray", stray_count, 32'd1);
        check_eq("t5_fill_unch", filled_count, 32'd2);

        // payload hold under backpressure, then reset mid-SEND
        open_order(32'd7, 8'd1, 8'h10, 32'd5000);
        place(32'd77, 8'd1);
        decide(1'b1);
        check_eq("t6_id", 32'(order_id), 32'h05);
        best_ask_price = 32'd6000; best_bid_price = 32'd1; trade_qty = 32'd1; trade_side = 8'd2;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_eq("t6_hold_valid", 32'(order_valid), 32'd1);
            check_eq("t6_hold_price", order_price, 32'd5000);
        end
        check_eq("t6_hold_qty", order_qty, 32'd77);
        check_eq("t6_hold_side", 32'(order_side), 32'd1);
        check_eq("t6_ocount", order_count, 32'd10);
        check_eq("t6_open", 32'(open_orders), 32'd1);
        rstn = 1'b0;
        #1;
        check_eq("t6_rst_valid", 32'(order_valid), 32'd0);
        check_eq("t6_rst_state", 32'(state_out), 32'd0);
        check_eq("t6_rst_open", 32'(open_orders), 32'd0);
        check_eq("t6_rst_ocount", order_count, 32'd0);
        check_eq("t6_rst_filled", filled_count, 32'd0);
        check_eq("t6_rst_id", 32'(order_id), 32'd0);
        check_eq("t6_rst_price", order_price, 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
